// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the programmable clock-enable controller.
package clkdiv_pkg;

  localparam int DEF_DIV_W  = 8;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STEP     = 2'd2,
    STOPPING = 2'd3
  } ctrl_state_t;

  // A programmed divisor of 0 behaves exactly like 1.
  function automatic logic [DEF_DIV_W-1:0] clamp_div(input logic [DEF_DIV_W-1:0] d);
    return (d == '0) ? DEF_DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/clkdiv_period_cnt.sv
// Period counter 0..div-1 with terminal-count flag and low-half compare; zero latency on flags.
// No backpressure: counts every cycle while enabled, held at 0 otherwise.
module clkdiv_period_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] count,
  output logic             last,
  output logic             low_half
);

  // div is already clamped to >= 1, so div-1 cannot wrap.
  assign last     = (count == (div - DIV_W'(1)));
  assign low_half = (count < (div >> 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || last) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Start/stop/step clock-enable controller; request in cycle 0 -> count 0 in cycle 1, first tick in cycle D.
// Divisor reload is valid/ready: one pending slot, cfg_ready low until it is applied at a period boundary.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = 100,
  parameter int STEP_W      = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              cfg_valid,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic              tick,
  output logic              divclk,
  output logic              running,
  output logic              done,
  output logic [DIV_W-1:0]  active_div
);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  count;
  logic              last;
  logic              low_half;
  logic [STEP_W-1:0] remaining;
  logic [DIV_W-1:0]  pend_div;
  logic              pend_vld;
  logic              hs;
  logic              step_start;
  logic              enter_idle;

  assign div_eff    = clamp_div(active_div);
  assign hs         = cfg_valid && cfg_ready;
  assign step_start = step_req && (step_count != '0);
  assign enter_idle = (state != IDLE) && (state_nxt == IDLE);

  clkdiv_period_cnt #(
    .DIV_W(DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (running),
    .div      (div_eff),
    .count    (count),
    .last     (last),
    .low_half (low_half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = RUN;
        end else if (step_start) begin
          state_nxt = STEP;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = last ? IDLE : STOPPING;
        end
      end
      STEP: begin
        if (stop) begin
          state_nxt = last ? IDLE : STOPPING;
        end else if (last && (remaining == STEP_W'(1))) begin
          state_nxt = IDLE;
        end
      end
      STOPPING: begin
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running   = (state != IDLE);
    tick      = running && last;
    divclk    = running && low_half;
    cfg_ready = !pend_vld;
  end

  // done marks the cycle after the final tick of a step run or a stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= enter_idle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if ((state == IDLE) && (state_nxt == STEP)) begin
      remaining <= step_count;
    end else if (state_nxt == IDLE) begin
      remaining <= '0;
    end else if ((state == STEP) && last && (remaining != '0)) begin
      remaining <= remaining - STEP_W'(1);
    end
  end

  // Outside IDLE a new divisor only lands on a period boundary, so no runt period is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_div <= DIV_W'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_vld   <= 1'b0;
    end else if (!running) begin
      if (hs) begin
        active_div <= cfg_div;
      end
    end else if (enter_idle) begin
      if (hs) begin
        active_div <= cfg_div;
      end else if (pend_vld) begin
        active_div <= pend_div;
      end
      pend_vld <= 1'b0;
    end else if (last && pend_vld) begin
      active_div <= pend_div;
      pend_vld   <= 1'b0;
    end else if (hs) begin
      pend_div <= cfg_div;
      pend_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_clkdiv_ctrl;

  localparam int DIV_W  = 8;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              step_req;
  logic [STEP_W-1:0] step_count;
  logic              cfg_valid;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_ready;
  logic              tick;
  logic              divclk;
  logic              running;
  logic              done;
  logic [DIV_W-1:0]  active_div;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clkdiv_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (100),
    .STEP_W      (STEP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step_req   (step_req),
    .step_count (step_count),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .tick       (tick),
    .divclk     (divclk),
    .running    (running),
    .done       (done),
    .active_div (active_div)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; step_req = 1'b0; step_count = '0;
    cfg_valid = 1'b0; cfg_div = '0;
    cyc();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b want=0", tick); end
    checks++; if (divclk !== 1'b0) begin failures++; $display("FAIL reset_divclk got=%0b want=0", divclk); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%0b want=0", running); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b want=1", cfg_ready); end
    checks++; if (active_div !== 8'd100) begin failures++; $display("FAIL reset_active_div got=%0d want=100", active_div); end
    rst = 1'b0;
    cyc(); cyc();
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%0b want=0", running); end
  endtask

  task automatic test_default_run();
    logic et, ed;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 200) stop = 1'b1;
      et = ((k % 100) == 0);
      ed = (((k - 1) % 100) < 50);
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL def_running c%0d got=%0b want=1", k, running); end
      checks++; if (tick !== et) begin failures++; $display("FAIL def_tick c%0d got=%0b want=%0b", k, tick, et); end
      checks++; if (divclk !== ed) begin failures++; $display("FAIL def_divclk c%0d got=%0b want=%0b", k, divclk, ed); end
      cyc();
    end
    stop = 1'b0;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL def_stop_running got=%0b want=0", running); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL def_stop_done got=%0b want=1", done); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL def_stop_tick got=%0b want=0", tick); end
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL def_done_width got=%0b want=0", done); end
  endtask

  task automatic test_cfg_idle_start();
    logic et, ed;
    cfg_valid = 1'b1; cfg_div = 8'd4; start = 1'b1;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_cfg_ready got=%0b want=1", cfg_ready); end
    cyc(); cfg_valid = 1'b0; start = 1'b0;
    checks++; if (active_div !== 8'd4) begin failures++; $display("FAIL idle_cfg_div got=%0d want=4", active_div); end
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) stop = 1'b1;
      et = ((k % 4) == 0);
      ed = (((k - 1) % 4) < 2);
      checks++; if (tick !== et) begin failures++; $display("FAIL d4_tick c%0d got=%0b want=%0b", k, tick, et); end
      checks++; if (divclk !== ed) begin failures++; $display("FAIL d4_divclk c%0d got=%0b want=%0b", k, divclk, ed); end
      cyc();
    end
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL d4_done got=%0b want=1", done); end
    cyc();
  endtask

  task automatic test_cfg_run();
    logic et, ed;
    int   c;
    cfg_valid = 1'b1; cfg_div = 8'd6; start = 1'b1;
    cyc(); cfg_valid = 1'b0; start = 1'b0;
    cyc();
    cfg_valid = 1'b1; cfg_div = 8'd3;
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL run_cfg_ready_pre got=%0b want=1", cfg_ready); end
    cyc(); cfg_valid = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      et = (k == 6);
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL run_cfg_ready_busy c%0d got=%0b want=0", k, cfg_ready); end
      checks++; if (active_div !== 8'd6) begin failures++; $display("FAIL run_active_old c%0d got=%0d want=6", k, active_div); end
      checks++; if (tick !== et) begin failures++; $display("FAIL run_tick_old c%0d got=%0b want=%0b", k, tick, et); end
      cyc();
    end
    checks++; if (active_div !== 8'd3) begin failures++; $display("FAIL run_active_new got=%0d want=3", active_div); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL run_cfg_ready_post got=%0b want=1", cfg_ready); end
    for (int k = 7; k <= 12; k++) begin
      if (k == 12) stop = 1'b1;
      c  = (k - 7) % 3;
      et = (c == 2);
      ed = (c < 1);
      checks++; if (tick !== et) begin failures++; $display("FAIL run_tick_new c%0d got=%0b want=%0b", k, tick, et); end
      checks++; if (divclk !== ed) begin failures++; $display("FAIL run_divclk_new c%0d got=%0b want=%0b", k, divclk, ed); end
      cyc();
    end
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL run_done got=%0b want=1", done); end
    cyc();
  endtask

  task automatic test_step();
    logic et, ed;
    cfg_valid = 1'b1; cfg_div = 8'd5;
    cyc(); cfg_valid = 1'b0;
    step_req = 1'b1; step_count = 8'd0;
    cyc(); step_req = 1'b0;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL step_zero_ignored got=%0b want=0", running); end
    step_req = 1'b1; step_count = 8'd3;
    cyc(); step_req = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      et = ((k % 5) == 0);
      ed = (((k - 1) % 5) < 2);
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL step_running c%0d got=%0b want=1", k, running); end
      checks++; if (tick !== et) begin failures++; $display("FAIL step_tick c%0d got=%0b want=%0b", k, tick, et); end
      checks++; if (divclk !== ed) begin failures++; $display("FAIL step_divclk c%0d got=%0b want=%0b", k, divclk, ed); end
      cyc();
    end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL step_end_running got=%0b want=0", running); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL step_end_done got=%0b want=1", done); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL step_end_tick got=%0b want=0", tick); end
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL step_done_width got=%0b want=0", done); end
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) stop = 1'b1;
      et = (k == 5);
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL restart_running c%0d got=%0b want=1", k, running); end
      checks++; if (tick !== et) begin failures++; $display("FAIL restart_tick c%0d got=%0b want=%0b", k, tick, et); end
      cyc();
    end
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL restart_done got=%0b want=1", done); end
    cyc();
  endtask

  task automatic test_stop_mid();
    logic et, ed;
    cfg_valid = 1'b1; cfg_div = 8'd8; start = 1'b1;
    cyc(); cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      stop = (k == 3);
      et = (k == 8);
      ed = ((k - 1) < 4);
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL stop_running c%0d got=%0b want=1", k, running); end
      checks++; if (tick !== et) begin failures++; $display("FAIL stop_tick c%0d got=%0b want=%0b", k, tick, et); end
      checks++; if (divclk !== ed) begin failures++; $display("FAIL stop_divclk c%0d got=%0b want=%0b", k, divclk, ed); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_early_done c%0d got=%0b want=0", k, done); end
      cyc();
    end
    stop = 1'b0;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_idle got=%0b want=0", running); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stop_done got=%0b want=1", done); end
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++; if (tick !== 1'b0) begin failures++; $display("FAIL stop_quiet_tick c%0d got=%0b want=0", k, tick); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_quiet_done c%0d got=%0b want=0", k, done); end
    end
  endtask

  task automatic test_zero_div_reset();
    cfg_valid = 1'b1; cfg_div = 8'd0;
    cyc(); cfg_valid = 1'b0;
    step_req = 1'b1; step_count = 8'd5;
    cyc(); step_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL d0_running c%0d got=%0b want=1", k, running); end
      checks++; if (tick !== 1'b1) begin failures++; $display("FAIL d0_tick c%0d got=%0b want=1", k, tick); end
      checks++; if (divclk !== 1'b0) begin failures++; $display("FAIL d0_divclk c%0d got=%0b want=0", k, divclk); end
      cyc();
    end
    rst = 1'b1;
    #1;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL arst_running got=%0b want=0", running); end
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL arst_tick got=%0b want=0", tick); end
    checks++; if (divclk !== 1'b0) begin failures++; $display("FAIL arst_divclk got=%0b want=0", divclk); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%0b want=0", done); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL arst_cfg_ready got=%0b want=1", cfg_ready); end
    checks++; if (active_div !== 8'd100) begin failures++; $display("FAIL arst_active_div got=%0d want=100", active_div); end
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_no_done got=%0b want=0", done); end
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL arst_stays_idle got=%0b want=0", running); end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_cfg_idle_start();
    test_cfg_run();
    test_step();
    test_stop_mid();
    test_zero_div_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
